// File: rtl/gf2m_poly_reducer_pkg.sv
// ---------------------------------------------------------------------------
// gf2m_poly_reducer_pkg
// Shared constants for the GF(2^521) datapath. The upstream Karatsuba
// multiplier and this reducer both import this package, so their field
// degree, product width and modulus always agree.
//   WIDTH      field degree m; width of a reduced field element
//   PROD_W     width of a carry-less product, 2*WIDTH
//   IDX_W      width of the bit-index counter that walks the product
//   POLY_TAIL  modulus x^521 + x^32 + 1 with its x^WIDTH term removed
//   state_e    reducer FSM states
// ---------------------------------------------------------------------------
package gf2m_poly_reducer_pkg;

  localparam int WIDTH  = 521;
  localparam int PROD_W = 2 * WIDTH;
  localparam int IDX_W  = $clog2(PROD_W);

  localparam logic [WIDTH-1:0] POLY_TAIL = 521'h1_0000_0001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage : gf2m_poly_reducer_pkg

// File: rtl/gf2m_reduce_step.sv
// ---------------------------------------------------------------------------
// gf2m_reduce_step
// One combinational reduction step. If bit idx of the working value is set,
// that x^idx term is replaced by x^(idx-WIDTH) * POLY_TAIL, which is the
// same value modulo x^WIDTH + POLY_TAIL. Otherwise the value passes through.
//   work_in   [PROD_W-1:0]  working polynomial before this step
//   idx       [IDX_W-1:0]   bit being eliminated, WIDTH <= idx <= PROD_W-1
//   work_out  [PROD_W-1:0]  working polynomial after this step
// ---------------------------------------------------------------------------
module gf2m_reduce_step
  import gf2m_poly_reducer_pkg::*;
(
  input  logic [PROD_W-1:0] work_in,
  input  logic [IDX_W-1:0]  idx,
  output logic [PROD_W-1:0] work_out
);

  // The tail has degree 32, so the shifted tail tops out at idx-489 and can
  // never reach bit idx or anything above it.
  localparam logic [PROD_W-1:0] TAIL_EXT = {{(PROD_W - WIDTH){1'b0}}, POLY_TAIL};

  logic [IDX_W-1:0]  shamt;
  logic [PROD_W-1:0] lead_bit;
  logic [PROD_W-1:0] tail_shifted;

  // Only meaningful while idx >= WIDTH; outside REDUCE the output is unused.
  assign shamt        = idx - IDX_W'(WIDTH);
  assign lead_bit     = PROD_W'(1) << idx;
  assign tail_shifted = TAIL_EXT << shamt;

  // NOTE: every output of a combinational block gets a default on entry, so
  //       no path through the block leaves it unassigned and no latch forms.
  always_comb begin
    work_out = work_in;
    if (work_in[idx]) begin
      work_out = work_in ^ lead_bit ^ tail_shifted;
    end
  end

endmodule : gf2m_reduce_step

// File: rtl/gf2m_poly_reducer.sv
// ---------------------------------------------------------------------------
// gf2m_poly_reducer
// Bit-serial reducer of a 1042-bit carry-less product modulo
// x^521 + x^32 + 1. It eliminates one product bit per clock, from the top
// bit down to bit WIDTH, so the latency is a fixed 521 reduce edges whatever
// the data. It uses a valid/ready handshake on both sides.
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_data    [PROD_W-1:0] carry-less product from the multiplier
//   in_valid   in_data valid
//   in_ready   block can accept in_data (high only in IDLE)
//   out_data   [WIDTH-1:0] reduced field element
//   out_valid  out_data valid; held until out_ready
//   out_ready  downstream accepts out_data
// ---------------------------------------------------------------------------
module gf2m_poly_reducer
  import gf2m_poly_reducer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  state_e            state_q,     state_d;
  logic [PROD_W-1:0] work_q,      work_d;
  logic [IDX_W-1:0]  idx_q,       idx_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [PROD_W-1:0] step_work;

  gf2m_reduce_step u_step (
    .work_in  (work_q),
    .idx      (idx_q),
    .work_out (step_work)
  );

  // Accept only from IDLE. A consumed result returns to IDLE first, so there
  // is no same-cycle DONE -> accept path.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          idx_d   = IDX_W'(PROD_W - 1);
          state_d = ST_REDUCE;
        end
      end

      ST_REDUCE: begin
        work_d = step_work;
        idx_d  = idx_q - 1'b1;
        // The result is taken from this edge's step output, so the final
        // elimination of bit WIDTH is included.
        if (idx_q == IDX_W'(WIDTH)) begin
          out_data_d  = step_work[WIDTH-1:0];
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  //       samples the values from before the edge, independent of ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule : gf2m_poly_reducer
